// File: rtl/clk_meter_pkg.sv
// Shared FSM encoding, counter-width default and duty helper for clk_meter.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        CKM_IDLE = 2'd0,
        CKM_ARM  = 2'd1,
        CKM_HIGH = 2'd2,
        CKM_LOW  = 2'd3
    } ckm_state_e;

    localparam int CKM_CNT_SZ_DEF = 16;

    // True when the two phase lengths differ by more than one cycle.
    function automatic logic ckm_duty_off(input logic [31:0] a, input logic [31:0] b);
        if (a > b) begin
            return (a - b) > 32'd1;
        end
        return (b - a) > 32'd1;
    endfunction

endpackage

// File: rtl/clk_meter_sync_edge.sv
// ns_sync_edge: SYNC_STG-flop synchronizer followed by one edge flop that
// yields single-cycle rise/fall strobes of the asynchronous input.
module ns_sync_edge #(
    parameter int SYNC_STG = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STG-1:0] sync_q;
    logic                edge_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], i_sig};
            edge_q <= sync_q[SYNC_STG-1];
        end
    end

    assign o_rise = sync_q[SYNC_STG-1] & ~edge_q;
    assign o_fall = ~sync_q[SYNC_STG-1] & edge_q;

endmodule

// File: rtl/clk_meter.sv
// clk_meter: measures high/low/period of an asynchronous square wave in i_clk
// cycles with a valid/ack result handshake. Optional macro NS_CLK_METER_DUTY_CHK_EN.
module clk_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_SZ   = CKM_CNT_SZ_DEF,
    parameter int SYNC_STG = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_sig,
    input  logic              i_ack,
    output logic              o_valid,
    output logic [CNT_SZ-1:0] o_high,
    output logic [CNT_SZ-1:0] o_low,
    output logic [CNT_SZ:0]   o_period,
    output logic              o_overrun,
    output logic              o_stuck,
    output logic              o_duty_err
);

    localparam logic [CNT_SZ-1:0] CNT_MAX = '1;
    localparam logic [CNT_SZ-1:0] CNT_ONE = {{(CNT_SZ-1){1'b0}}, 1'b1};

    ckm_state_e        state_q, state_d;
    logic [CNT_SZ-1:0] cnt_q, cnt_d;
    logic [CNT_SZ-1:0] cnt_high_q, cnt_high_d;
    logic [CNT_SZ-1:0] high_q, high_d;
    logic [CNT_SZ-1:0] low_q, low_d;
    logic [CNT_SZ:0]   period_q, period_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              stuck_q, stuck_d;
    logic              rise, fall;
    logic              pub, load;
    logic [CNT_SZ-1:0] cnt_inc;

    ns_sync_edge #(
        .SYNC_STG (SYNC_STG)
    ) u_sync_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_sig),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    // Never wraps where it is used: saturation is checked before any edge.
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_high_d = cnt_high_q;
        high_d     = high_q;
        low_d      = low_q;
        period_d   = period_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        stuck_d    = stuck_q;
        pub        = 1'b0;
        load       = 1'b0;

        if (valid_q && i_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
            stuck_d   = 1'b0;
        end

        if (!i_enable) begin
            state_d = CKM_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CKM_IDLE: state_d = CKM_ARM;
                CKM_ARM: begin
                    if (rise) begin
                        state_d = CKM_HIGH;
                        cnt_d   = '0;
                    end
                end
                CKM_HIGH: begin
                    if (cnt_q == CNT_MAX) begin
                        stuck_d = 1'b1;
                        state_d = CKM_ARM;
                        cnt_d   = '0;
                    end else if (fall) begin
                        cnt_high_d = cnt_inc;
                        cnt_d      = '0;
                        state_d    = CKM_LOW;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                CKM_LOW: begin
                    if (cnt_q == CNT_MAX) begin
                        stuck_d = 1'b1;
                        state_d = CKM_ARM;
                        cnt_d   = '0;
                    end else if (rise) begin
                        pub     = 1'b1;
                        cnt_d   = '0;
                        state_d = CKM_HIGH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = CKM_IDLE;
            endcase
        end

        // A same-cycle ack frees the result registers for the new measurement.
        if (pub) begin
            if (!valid_q || i_ack) begin
                load     = 1'b1;
                high_d   = cnt_high_q;
                low_d    = cnt_inc;
                period_d = {1'b0, cnt_high_q} + {1'b0, cnt_inc};
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= CKM_IDLE;
            cnt_q      <= '0;
            cnt_high_q <= '0;
            high_q     <= '0;
            low_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cnt_high_q <= cnt_high_d;
            high_q     <= high_d;
            low_q      <= low_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            stuck_q    <= stuck_d;
        end
    end

`ifdef NS_CLK_METER_DUTY_CHK_EN
    logic duty_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            duty_q <= 1'b0;
        end else if (load) begin
            duty_q <= ckm_duty_off(32'(cnt_high_q), 32'(cnt_inc));
        end
    end

    assign o_duty_err = duty_q;
`else
    assign o_duty_err = 1'b0;
`endif

    assign o_valid   = valid_q;
    assign o_high    = high_q;
    assign o_low     = low_q;
    assign o_period  = period_q;
    assign o_overrun = overrun_q;
    assign o_stuck   = stuck_q;

endmodule

// File: tb/tb_clk_meter.sv
// Directed self-checking bench for clk_meter (CNT_SZ=8, SYNC_STG=2).
module tb_clk_meter;
    import clk_meter_pkg::*;

    localparam int CNT_SZ = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              sig;
    logic              ack;
    logic              valid;
    logic [CNT_SZ-1:0] high;
    logic [CNT_SZ-1:0] low;
    logic [CNT_SZ:0]   period;
    logic              overrun;
    logic              stuck;
    logic              duty_err;

    int errors = 0;
    int checks = 0;

    // Waveform source controls, written by the main sequence.
    logic gen_on    = 1'b0;
    logic gen_level = 1'b0;
    int   hi_len    = 2;
    int   lo_len    = 2;

`ifdef NS_CLK_METER_DUTY_CHK_EN
    localparam logic DUTY_3_6 = 1'b1;
`else
    localparam logic DUTY_3_6 = 1'b0;
`endif

    always #5 clk = ~clk;

    clk_meter #(
        .CNT_SZ   (CNT_SZ),
        .SYNC_STG (2)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_enable   (enable),
        .i_sig      (sig),
        .i_ack      (ack),
        .o_valid    (valid),
        .o_high     (high),
        .o_low      (low),
        .o_period   (period),
        .o_overrun  (overrun),
        .o_stuck    (stuck),
        .o_duty_err (duty_err)
    );

    // Signal under test: hi_len cycles high then lo_len cycles low, starting high.
    initial begin
        int gcnt;
        gcnt = 0;
        sig  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!gen_on) begin
                sig  = gen_level;
                gcnt = 0;
            end else begin
                sig  = (gcnt < hi_len);
                gcnt = (gcnt + 1 >= hi_len + lo_len) ? 0 : gcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < limit) begin
            cyc(1);
            n++;
        end
        chk({tag, "_valid"}, 32'(valid), 32'd1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int h, input int l);
        chk({tag, "_high"}, 32'(high), 32'(h));
        chk({tag, "_low"}, 32'(low), 32'(l));
        chk({tag, "_period"}, 32'(period), 32'(h + l));
        $display("txn %s high=%0d low=%0d period=%0d duty_err=%0d", tag, high, low, period, duty_err);
    endtask

    task automatic quiesce();
        enable = 1'b0;
        gen_on = 1'b0;
        gen_level = 1'b0;
        cyc(6);
        pulse_ack();
        cyc(2);
    endtask

    task automatic start(input int h, input int l);
        hi_len = h;
        lo_len = l;
        enable = 1'b1;
        gen_on = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_high", 32'(high), 32'd0);
        chk("rst_low", 32'(low), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_stuck", 32'(stuck), 32'd0);
        chk("rst_duty", 32'(duty_err), 32'd0);

        // Divider lim=1: 2 high, 2 low, each result acknowledged.
        start(2, 2);
        for (int i = 0; i < 3; i++) begin
            wait_valid("lim1", 40);
            expect_result("lim1", 2, 2);
            pulse_ack();
        end
        quiesce();

        // Divider lim=200.
        start(201, 201);
        for (int i = 0; i < 2; i++) begin
            wait_valid("lim200", 1000);
            expect_result("lim200", 201, 201);
            pulse_ack();
        end
        quiesce();

        // Unacknowledged result: a second period overruns, the first stays latched.
        start(2, 2);
        wait_valid("ovr", 40);
        expect_result("ovr_first", 2, 2);
        chk("ovr_initial", 32'(overrun), 32'd0);
        cyc(5);
        chk("ovr_valid_held", 32'(valid), 32'd1);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_high_held", 32'(high), 32'd2);
        pulse_ack();
        chk("ovr_ack_valid", 32'(valid), 32'd0);
        chk("ovr_ack_overrun", 32'(overrun), 32'd0);

        // Ack coinciding with a publish: new result loads, no overrun.
        wait_valid("ackpub", 40);
        cyc(3);
        pulse_ack();
        chk("ackpub_valid", 32'(valid), 32'd1);
        chk("ackpub_overrun", 32'(overrun), 32'd0);
        quiesce();

        // Signal stopped high after one rising edge: counter saturates at 255.
        enable = 1'b1;
        cyc(3);
        gen_level = 1'b1;
        cyc(200);
        chk("stuck_early", 32'(stuck), 32'd0);
        cyc(100);
        chk("stuck_set", 32'(stuck), 32'd1);
        chk("stuck_valid", 32'(valid), 32'd0);
        chk("stuck_state_arm", 32'(dut.state_q), 32'(CKM_ARM));
        gen_level = 1'b0;
        cyc(5);

        // Reset in the middle of a high phase.
        start(3, 3);
        wait_valid("prerst", 60);
        expect_result("prerst", 3, 3);
        chk("prerst_stuck_sticky", 32'(stuck), 32'd1);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_high", 32'(high), 32'd0);
        chk("midrst_low", 32'(low), 32'd0);
        chk("midrst_period", 32'(period), 32'd0);
        chk("midrst_stuck", 32'(stuck), 32'd0);
        rst = 1'b0;
        wait_valid("postrst", 60);
        expect_result("postrst", 3, 3);
        pulse_ack();
        quiesce();

        // Duty check: 3/6 is off by more than one, 4/5 is not.
        start(3, 6);
        wait_valid("duty36", 60);
        expect_result("duty36", 3, 6);
        chk("duty36_err", 32'(duty_err), 32'(DUTY_3_6));
        pulse_ack();
        quiesce();

        start(4, 5);
        wait_valid("duty45", 60);
        expect_result("duty45", 4, 5);
        chk("duty45_err", 32'(duty_err), 32'd0);
        pulse_ack();
        quiesce();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
